hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the 5-stage RISC-V core; sits in ID beside the forwarding unit and drives the enables and flushes of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three cases that forwarding cannot:
- load-use hazards, with a one-cycle bubble;
- taken branches and jumps resolved in EX, by flushing the wrong path;
- multi-cycle data-memory accesses, with a full freeze and a timeout watchdog.

It also keeps saturating stall and flush counters for performance monitoring.

## Interface
Parameters:
- CNT_W, 16, width of stall_cnt and flush_cnt.
- MEM_TIMEOUT, 255, number of consecutive not-ready memory cycles that triggers the error. Legal range is 2..2^TO_W-1.
- TO_W, 8, width of the internal wait counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_ex_mem_read  in  1  the instruction in EX is a load.
- id_ex_rd  in  5  destination register of the instruction in EX.
- if_id_rs1, if_id_rs2  in  5 each  source registers of the instruction in ID.
- if_id_rs1_used, if_id_rs2_used  in  1 each  the ID instruction actually reads rs1 / rs2.
- ex_branch_taken  in  1  a branch or jump resolved taken in EX this cycle.
- dmem_req  in  1  the instruction in MEM accesses data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_write, if_id_write, id_ex_write, ex_mem_write  out  1 each  register load enables.
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a NOP bubble. A flush takes priority over a write enable.
- stall_cnt  out  CNT_W  count of stall cycles.
- flush_cnt  out  CNT_W  count of branch-flush cycles.
- mem_timeout_err  out  1  sticky memory-timeout error.
- hazard_state  out  2  current state: RUN=00, MEM_WAIT=01, ERROR=11.

## Operation
- Control outputs are combinational functions of the registered state and the current inputs. State, the wait counter and the perf counters are registered.
- The load-use condition `lu` is true when all of the following hold:
  - id_ex_mem_read = 1;
  - id_ex_rd != 0;
  - (if_id_rs1_used and if_id_rs1 == id_ex_rd) or (if_id_rs2_used and if_id_rs2 == id_ex_rd).
- Default outputs: all write enables = 1 and all flushes = 0.
- RUN state, checked in priority order:
  1. **Freeze** when dmem_req=1 and dmem_ready=0.
     - All write enables = 0; mem_wb_flush = 1.
     - Next state MEM_WAIT; wait_cnt <= 1.
     - stall_cnt increments.
     - ex_branch_taken and `lu` are ignored this cycle.
  2. **Branch flush** when ex_branch_taken = 1.
     - if_id_flush = 1 and id_ex_flush = 1; pc_write = 1, so the PC loads the target.
     - flush_cnt increments.
     - Overrides `lu`, because the ID instruction is wrong-path.
  3. **Load-use stall** when `lu` is true.
     - pc_write = 0, if_id_write = 0, id_ex_flush = 1.
     - stall_cnt increments.
  4. Otherwise, defaults.
- MEM_WAIT state:
  - When dmem_ready = 0:
    - Outputs are as for Freeze; stall_cnt increments.
    - If wait_cnt == MEM_TIMEOUT-1, next state is ERROR. Otherwise wait_cnt increments.
  - When dmem_ready = 1:
    - The freeze lifts this cycle, and branch flush, load-use and defaults are evaluated exactly as in RUN, priorities 2-4.
    - Next state is RUN.
    - The freeze check is not re-applied on this cycle.
- ERROR state:
  - Outputs are as for Freeze, permanently.
  - mem_timeout_err = 1.
  - Counters hold.
  - Only rst exits this state.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset:
  - state = RUN, wait_cnt = 0, stall_cnt = 0, flush_cnt = 0, mem_timeout_err = 0.
  - While rst = 1, all write enables = 0 and all flushes = 1, independent of the clock.
- Load-use costs exactly one bubble cycle. On the next cycle id_ex_mem_read is 0 (the bubble), so `lu` clears.
- Branch flush costs one cycle. Back-to-back taken branches flush on every cycle.
- A memory access of N cycles, meaning ready is asserted on cycle N:
  - gives N-1 frozen cycles;
  - for N-1 < MEM_TIMEOUT, never errors.
- ERROR is entered on the clock edge that ends the MEM_TIMEOUT-th consecutive not-ready cycle. mem_timeout_err is high from that edge onward.
- Reset asserted mid-freeze or mid-stall returns to RUN asynchronously, clears the counters, and drops the error flag.

## Test plan
- Load-use:
  - Stimulus: id_ex_mem_read=1, id_ex_rd=5, if_id_rs2=5, if_id_rs2_used=1.
  - Response: one cycle with pc_write=0, if_id_write=0, id_ex_flush=1; stall_cnt 0→1.
  - Repeat with id_ex_rd=0, or with if_id_rs2_used=0: no stall.
- Branch vs load-use:
  - Stimulus: ex_branch_taken=1 together with the load-use condition.
  - Response: if_id_flush=1, id_ex_flush=1, pc_write=1; stall_cnt unchanged; flush_cnt +1.
- Three-cycle memory access:
  - Stimulus: dmem_req=1, with dmem_ready = 0, 0, 1 on successive cycles.
  - Response: two frozen cycles with mem_wb_flush=1 and hazard_state=01, then RUN; stall_cnt=2.
- Timeout:
  - Stimulus: MEM_TIMEOUT=4, dmem_req=1, dmem_ready held at 0.
  - Response: hazard_state=11 and mem_timeout_err=1 after the 4th edge. The state stays frozen after dmem_ready rises and clears only on rst.
- Ready cycle with branch:
  - Stimulus: in MEM_WAIT, dmem_ready=1 and ex_branch_taken=1 in the same cycle.
  - Response: ex_mem_write=1, if_id_flush=1, id_ex_flush=1; next state RUN.
- Saturation and async reset:
  - Stimulus: CNT_W=2 with 5 load-use stalls, then rst pulsed between clock edges.
  - Response: stall_cnt stops at 3. On rst, all outputs go to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard controller for the 5-stage RISC-V core.
// It drives the pipeline register enables and flushes for three cases:
//   - load-use stalls;
//   - taken-branch flushes;
//   - multi-cycle data-memory freezes, with a timeout watchdog.
// It also keeps saturating stall and flush counters.
module hazard_unit #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rd,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             if_id_rs1_used,
    input  logic             if_id_rs2_used,
    input  logic             ex_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout_err,
    output logic [1:0]       hazard_state
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERROR    = 2'b11
    } state_t;

    // wait_cnt holds the number of consecutive not-ready cycles seen so far.
    // Reaching WAIT_LAST while still not ready means this cycle is the last allowed.
    localparam logic [TO_W-1:0]  WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t          state;
    logic [TO_W-1:0] wait_cnt;
    logic            lu;
    logic            mem_busy;
    logic            freeze;
    logic            stall_inc;
    logic            flush_inc;

    assign lu = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                ((if_id_rs1_used && (if_id_rs1 == id_ex_rd)) ||
                 (if_id_rs2_used && (if_id_rs2 == id_ex_rd)));

    assign mem_busy        = dmem_req && !dmem_ready;
    assign mem_timeout_err = (state == ERROR);
    assign hazard_state    = state;

    // Decode the current state and inputs into enables, flushes and counter events.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        freeze       = 1'b1;

        unique case (state)
            RUN:      freeze = mem_busy;
            MEM_WAIT: freeze = !dmem_ready;
            default:  freeze = 1'b1;
        endcase

        if (freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
            stall_inc    = (state != ERROR);
        end else if (ex_branch_taken) begin
            // The ID instruction is wrong-path, so a pending load-use is moot.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
        end else if (lu) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
        end

        // Reset holds the whole pipeline in bubbles without waiting for a clock edge.
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
            stall_inc    = 1'b0;
            flush_inc    = 1'b0;
        end
    end

    // Track the memory-wait sequence and the sticky timeout state.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the values from before the clock edge.
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (mem_busy) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= TO_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                default: state <= ERROR;
            endcase
        end
    end

    // Saturating performance counters for stall and branch-flush cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit. There are two instances:
//   - a wide-counter instance;
//   - a 2-bit-counter instance for saturation.
// Both share one stimulus stream and use a short memory timeout.
module tb_hazard_unit;

    localparam int TO = 4;

    typedef struct {
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       br;
        logic       req;
        logic       rdy;
    } in_t;

    typedef struct {
        in_t        in;
        logic [6:0] ctl;
        int         dst;
        int         dfl;
    } vec_t;

    // Control vector order: pc_w, if_id_w, id_ex_w, ex_mem_w, if_id_f, id_ex_f, mem_wb_f
    localparam logic [6:0] C_DEF   = 7'b1111000;
    localparam logic [6:0] C_LU    = 7'b0011010;
    localparam logic [6:0] C_BR    = 7'b1111110;
    localparam logic [6:0] C_FRZ   = 7'b0000001;
    localparam logic [6:0] C_RESET = 7'b0000111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic id_ex_mem_read = 1'b0;
    logic [4:0] id_ex_rd = '0, if_id_rs1 = '0, if_id_rs2 = '0;
    logic if_id_rs1_used = 1'b0, if_id_rs2_used = 1'b0;
    logic ex_branch_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;

    logic pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout_err;
    logic [15:0] stall_cnt, flush_cnt;
    logic [1:0]  hazard_state;

    logic s_pc_write, s_if_id_write, s_id_ex_write, s_ex_mem_write;
    logic s_if_id_flush, s_id_ex_flush, s_mem_wb_flush, s_mem_timeout_err;
    logic [1:0] s_stall_cnt, s_flush_cnt, s_hazard_state;

    logic [6:0] ctl, s_ctl;
    assign ctl   = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                    if_id_flush, id_ex_flush, mem_wb_flush};
    assign s_ctl = {s_pc_write, s_if_id_write, s_id_ex_write, s_ex_mem_write,
                    s_if_id_flush, s_id_ex_flush, s_mem_wb_flush};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_unit #(.CNT_W(16), .MEM_TIMEOUT(TO), .TO_W(8)) dut (
        .clk(clk), .rst(rst),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .if_id_rs1_used(if_id_rs1_used), .if_id_rs2_used(if_id_rs2_used),
        .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
        .ex_mem_write(ex_mem_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_wb_flush(mem_wb_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .mem_timeout_err(mem_timeout_err), .hazard_state(hazard_state)
    );

    hazard_unit #(.CNT_W(2), .MEM_TIMEOUT(TO), .TO_W(3)) dut_sat (
        .clk(clk), .rst(rst),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .if_id_rs1_used(if_id_rs1_used), .if_id_rs2_used(if_id_rs2_used),
        .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(s_pc_write), .if_id_write(s_if_id_write), .id_ex_write(s_id_ex_write),
        .ex_mem_write(s_ex_mem_write), .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
        .mem_wb_flush(s_mem_wb_flush), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt),
        .mem_timeout_err(s_mem_timeout_err), .hazard_state(s_hazard_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic u1, input logic u2,
                               input logic br, input logic req, input logic rdy);
        in_t v;
        v.mr = mr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.br = br; v.req = req; v.rdy = rdy;
        return v;
    endfunction

    task automatic set_in(input in_t v);
        id_ex_mem_read  = v.mr;
        id_ex_rd        = v.rd;
        if_id_rs1       = v.rs1;
        if_id_rs2       = v.rs2;
        if_id_rs1_used  = v.u1;
        if_id_rs2_used  = v.u2;
        ex_branch_taken = v.br;
        dmem_req        = v.req;
        dmem_ready      = v.rdy;
    endtask

    // Called one time unit after a rising edge; returns at the same phase.
    task automatic do_reset();
        rst = 1'b1;
        set_in(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference-model state for the random phase.
    int  m_nr;
    bit  m_err;
    int  m_st, m_fl;

    function automatic int sat2(input int n);
        return (n > 3) ? 3 : n;
    endfunction

    vec_t tbl[9];
    int   exp_st, exp_fl;

    initial begin
        in_t       v;
        in_t       lu_in;
        bit        frz, lu_m;
        logic [6:0] exp_ctl;
        int        exp_state;

        // ---- reset values, before any clock edge ----
        #2;
        check("reset_ctl", 32'(ctl), 32'(C_RESET));
        check("reset_state", 32'(hazard_state), 32'd0);
        check("reset_err", 32'(mem_timeout_err), 32'd0);
        check("reset_stall", 32'(stall_cnt), 32'd0);
        check("reset_flush", 32'(flush_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_ctl", 32'(ctl), 32'(C_DEF));
        @(posedge clk);
        #1;

        // ---- table-driven single-cycle behaviour from RUN ----
        tbl[0] = '{mk(1, 5, 0, 5, 0, 1, 0, 0, 0), C_LU,  1, 0};  // load-use on rs2
        tbl[1] = '{mk(1, 0, 0, 0, 0, 1, 0, 0, 0), C_DEF, 0, 0};  // rd = x0
        tbl[2] = '{mk(1, 5, 0, 5, 0, 0, 0, 0, 0), C_DEF, 0, 0};  // rs2 not used
        tbl[3] = '{mk(1, 7, 7, 3, 1, 0, 0, 0, 0), C_LU,  1, 0};  // load-use on rs1
        tbl[4] = '{mk(1, 7, 7, 3, 0, 1, 0, 0, 0), C_DEF, 0, 0};  // rs1 match unused
        tbl[5] = '{mk(0, 5, 5, 5, 1, 1, 0, 0, 0), C_DEF, 0, 0};  // not a load
        tbl[6] = '{mk(1, 5, 0, 5, 0, 1, 1, 0, 0), C_BR,  0, 1};  // branch beats load-use
        tbl[7] = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 0), C_BR,  0, 1};  // plain branch
        tbl[8] = '{mk(1, 9, 9, 0, 1, 0, 0, 1, 1), C_LU,  1, 0};  // ready memory, no freeze
        exp_st = 0;
        exp_fl = 0;
        for (int i = 0; i < 9; i++) begin
            set_in(tbl[i].in);
            @(negedge clk);
            check($sformatf("tbl%0d_ctl", i), 32'(ctl), 32'(tbl[i].ctl));
            check($sformatf("tbl%0d_state", i), 32'(hazard_state), 32'd0);
            next_cycle();
            exp_st += tbl[i].dst;
            exp_fl += tbl[i].dfl;
            check($sformatf("tbl%0d_stall", i), 32'(stall_cnt), 32'(exp_st));
            check($sformatf("tbl%0d_flush", i), 32'(flush_cnt), 32'(exp_fl));
        end

        // ---- back-to-back taken branches flush on every cycle ----
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
            @(negedge clk);
            check("b2b_ctl", 32'(ctl), 32'(C_BR));
            next_cycle();
        end
        check("b2b_flush", 32'(flush_cnt), 32'd3);

        // ---- three-cycle memory access, then ready together with a branch ----
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(mk(0, 0, 0, 0, 0, 0, 0, 1, (i == 2)));
            @(negedge clk);
            check($sformatf("mem3_c%0d_ctl", i), 32'(ctl), 32'((i == 2) ? C_DEF : C_FRZ));
            check($sformatf("mem3_c%0d_state", i), 32'(hazard_state), 32'((i == 0) ? 0 : 1));
            next_cycle();
        end
        check("mem3_state_after", 32'(hazard_state), 32'd0);
        check("mem3_stall", 32'(stall_cnt), 32'd2);

        set_in(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        next_cycle();
        set_in(mk(1, 4, 4, 0, 1, 0, 1, 1, 1));
        @(negedge clk);
        check("rdybr_ctl", 32'(ctl), 32'(C_BR));
        check("rdybr_state", 32'(hazard_state), 32'd1);
        next_cycle();
        check("rdybr_state_after", 32'(hazard_state), 32'd0);
        check("rdybr_flush", 32'(flush_cnt), 32'd1);
        check("rdybr_stall", 32'(stall_cnt), 32'd3);

        // ---- timeout watchdog ----
        do_reset();
        for (int i = 1; i <= TO; i++) begin
            set_in(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
            @(negedge clk);
            check($sformatf("to_c%0d_ctl", i), 32'(ctl), 32'(C_FRZ));
            check($sformatf("to_c%0d_err", i), 32'(mem_timeout_err), 32'd0);
            next_cycle();
        end
        check("to_state", 32'(hazard_state), 32'd3);
        check("to_err", 32'(mem_timeout_err), 32'd1);
        check("to_stall", 32'(stall_cnt), 32'd4);
        for (int i = 0; i < 2; i++) begin
            set_in(mk(0, 0, 0, 0, 0, 0, 1, 1, 1));
            @(negedge clk);
            check("err_ctl", 32'(ctl), 32'(C_FRZ));
            next_cycle();
            check("err_state", 32'(hazard_state), 32'd3);
            check("err_stall_hold", 32'(stall_cnt), 32'd4);
            check("err_flush_hold", 32'(flush_cnt), 32'd0);
        end
        // Asynchronous reset from ERROR, between clock edges.
        rst = 1'b1;
        #1;
        check("arst_err_state", 32'(hazard_state), 32'd0);
        check("arst_err_flag", 32'(mem_timeout_err), 32'd0);
        check("arst_err_stall", 32'(stall_cnt), 32'd0);
        check("arst_err_ctl", 32'(ctl), 32'(C_RESET));
        @(negedge clk);
        rst = 1'b0;
        next_cycle();

        // ---- counter saturation, then async reset mid-stall ----
        do_reset();
        lu_in = mk(1, 6, 6, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            set_in(lu_in);
            next_cycle();
        end
        check("sat_stall_narrow", 32'(s_stall_cnt), 32'd3);
        check("sat_stall_wide", 32'(stall_cnt), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        check("arst_stall_ctl", 32'(ctl), 32'(C_RESET));
        check("arst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("arst_stall_narrow", 32'(s_stall_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();

        // ---- randomized stimulus against the reference model ----
        do_reset();
        m_nr = 0; m_err = 0; m_st = 0; m_fl = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ((m_err && $urandom_range(0, 2) == 0) || $urandom_range(0, 99) == 0) begin
                do_reset();
                m_nr = 0; m_err = 0; m_st = 0; m_fl = 0;
            end
            v = mk($urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                   $urandom_range(0, 1));
            set_in(v);

            lu_m = v.mr && (v.rd != 0) &&
                   ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
            // A memory wait is in progress while the not-ready streak is non-zero.
            frz = m_err || ((m_nr > 0) ? !v.rdy : (v.req && !v.rdy));
            if (frz)       exp_ctl = C_FRZ;
            else if (v.br) exp_ctl = C_BR;
            else if (lu_m) exp_ctl = C_LU;
            else           exp_ctl = C_DEF;
            exp_state = m_err ? 3 : ((m_nr > 0) ? 1 : 0);

            @(negedge clk);
            check("rnd_ctl", 32'(ctl), 32'(exp_ctl));
            check("rnd_ctl_narrow", 32'(s_ctl), 32'(exp_ctl));
            check("rnd_state", 32'(hazard_state), 32'(exp_state));
            check("rnd_err", 32'(mem_timeout_err), 32'(m_err));
            check("rnd_stall", 32'(stall_cnt), 32'(m_st));
            check("rnd_flush", 32'(flush_cnt), 32'(m_fl));
            check("rnd_stall_narrow", 32'(s_stall_cnt), 32'(sat2(m_st)));
            check("rnd_flush_narrow", 32'(s_flush_cnt), 32'(sat2(m_fl)));

            if (!m_err) begin
                if (frz) begin
                    m_st++;
                    m_nr++;
                    if (m_nr == TO) m_err = 1;
                end else begin
                    m_nr = 0;
                    if (v.br)      m_fl++;
                    else if (lu_m) m_st++;
                end
            end
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
